// File: rtl/simon_round_sequencer.sv
// SIMON round sequencer: LOAD, ROUNDS x 3 datapath steps, DONE pulse; drives mux selects and round-key address.
// Optional abort input enabled by defining SIMON_SEQ_ABORT_EN.
module simon_round_sequencer #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned KEY_SIZE  = 128,
  parameter int unsigned ROUNDS    = 68,
  parameter int unsigned STEPS     = 3
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SIMON_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  input  logic       decrypt,
  output logic       busy,
  output logic       done,
  output logic       load_en,
  output logic [1:0] step_sel,
  output logic       xor_src,
  output logic       swap_en,
  output logic [7:0] round_idx,
  output logic [7:0] rk_addr
);

  if (WORD_SIZE == 0 || KEY_SIZE == 0 || ROUNDS < 1 || ROUNDS > 255 || STEPS != 3) begin : g_bad_cfg
    $error("simon_round_sequencer: unsupported parameter set");
  end

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [7:0] round_q, round_d;
  logic       mode_q, mode_d;
  logic       abort_w;

`ifdef SIMON_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  logic       busy_d, done_d, load_en_d, xor_src_d, swap_en_d;
  logic [1:0] step_sel_d;
  logic [7:0] round_idx_d, rk_addr_d;
  logic       in_round_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = decrypt;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        step_d  = '0;
        round_d = '0;
      end
      S_ROUND: begin
        if (step_q == 2'd2) begin
          step_d = '0;
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
            round_d = '0;
          end else begin
            round_d = round_q + 8'd1;
          end
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        round_d = '0;
      end
    endcase

    if (abort_w && (state_q == S_LOAD || state_q == S_ROUND)) begin
      state_d = S_IDLE;
      step_d  = '0;
      round_d = '0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    in_round_d  = (state_d == S_ROUND);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    load_en_d   = (state_d == S_LOAD);
    step_sel_d  = in_round_d ? step_d : '0;
    xor_src_d   = in_round_d && (step_d == 2'd0);
    swap_en_d   = in_round_d && (step_d == 2'd2);
    round_idx_d = in_round_d ? round_d : '0;
    rk_addr_d   = '0;
    if (in_round_d) begin
      rk_addr_d = mode_d ? (LAST_ROUND - round_d) : round_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      round_q   <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_en   <= 1'b0;
      step_sel  <= '0;
      xor_src   <= 1'b0;
      swap_en   <= 1'b0;
      round_idx <= '0;
      rk_addr   <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      round_q   <= round_d;
      mode_q    <= mode_d;
      busy      <= busy_d;
      done      <= done_d;
      load_en   <= load_en_d;
      step_sel  <= step_sel_d;
      xor_src   <= xor_src_d;
      swap_en   <= swap_en_d;
      round_idx <= round_idx_d;
      rk_addr   <= rk_addr_d;
    end
  end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Directed bench for simon_round_sequencer: instances with ROUNDS = 68, 4 and 1.
module tb_simon_round_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start [3];
  logic       decrypt [3];
  logic       busy [3];
  logic       done [3];
  logic       load_en [3];
  logic [1:0] step_sel [3];
  logic       xor_src [3];
  logic       swap_en [3];
  logic [7:0] round_idx [3];
  logic [7:0] rk_addr [3];
`ifdef SIMON_SEQ_ABORT_EN
  logic       abort [3];
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simon_round_sequencer #(.ROUNDS(68)) u68 (
    .clk(clk), .reset(reset),
`ifdef SIMON_SEQ_ABORT_EN
    .abort(abort[0]),
`endif
    .start(start[0]), .decrypt(decrypt[0]), .busy(busy[0]), .done(done[0]),
    .load_en(load_en[0]), .step_sel(step_sel[0]), .xor_src(xor_src[0]),
    .swap_en(swap_en[0]), .round_idx(round_idx[0]), .rk_addr(rk_addr[0])
  );

  simon_round_sequencer #(.ROUNDS(4)) u4 (
    .clk(clk), .reset(reset),
`ifdef SIMON_SEQ_ABORT_EN
    .abort(abort[1]),
`endif
    .start(start[1]), .decrypt(decrypt[1]), .busy(busy[1]), .done(done[1]),
    .load_en(load_en[1]), .step_sel(step_sel[1]), .xor_src(xor_src[1]),
    .swap_en(swap_en[1]), .round_idx(round_idx[1]), .rk_addr(rk_addr[1])
  );

  simon_round_sequencer #(.ROUNDS(1)) u1 (
    .clk(clk), .reset(reset),
`ifdef SIMON_SEQ_ABORT_EN
    .abort(abort[2]),
`endif
    .start(start[2]), .decrypt(decrypt[2]), .busy(busy[2]), .done(done[2]),
    .load_en(load_en[2]), .step_sel(step_sel[2]), .xor_src(xor_src[2]),
    .swap_en(swap_en[2]), .round_idx(round_idx[2]), .rk_addr(rk_addr[2])
  );

  typedef struct {
    bit       busy;
    bit       done;
    bit       load;
    bit [1:0] sel;
    bit       xsrc;
    bit       swap;
    bit [7:0] rnd;
    bit [7:0] rk;
  } exp_t;

  typedef struct {
    bit   start;
    bit   dec;
    exp_t e;
  } vec_t;

  function automatic exp_t mkexp(bit b, bit d, bit l, bit [1:0] s, bit x, bit w, bit [7:0] r, bit [7:0] k);
    exp_t e;
    e.busy = b; e.done = d; e.load = l; e.sel = s;
    e.xsrc = x; e.swap = w; e.rnd = r; e.rk = k;
    return e;
  endfunction

  // Expected outputs k cycles after the edge that accepted start.
  function automatic exp_t model(int k, int nr, bit dec);
    exp_t e;
    int j, s, r;
    e = mkexp(0, 0, 0, 2'd0, 0, 0, 8'd0, 8'd0);
    if (k >= 1 && k <= 2 + 3 * nr) e.busy = 1'b1;
    if (k == 1) e.load = 1'b1;
    if (k == 2 + 3 * nr) e.done = 1'b1;
    if (k >= 2 && k <= 1 + 3 * nr) begin
      j = k - 2;
      s = j % 3;
      r = j / 3;
      e.sel  = 2'(s);
      e.xsrc = (s == 0);
      e.swap = (s == 2);
      e.rnd  = 8'(r);
      e.rk   = dec ? 8'(nr - 1 - r) : 8'(r);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_all(input int i, input exp_t e, input string tag);
    chk({tag, ".busy"},      int'(busy[i]),      int'(e.busy));
    chk({tag, ".done"},      int'(done[i]),      int'(e.done));
    chk({tag, ".load_en"},   int'(load_en[i]),   int'(e.load));
    chk({tag, ".step_sel"},  int'(step_sel[i]),  int'(e.sel));
    chk({tag, ".xor_src"},   int'(xor_src[i]),   int'(e.xsrc));
    chk({tag, ".swap_en"},   int'(swap_en[i]),   int'(e.swap));
    chk({tag, ".round_idx"}, int'(round_idx[i]), int'(e.rnd));
    chk({tag, ".rk_addr"},   int'(rk_addr[i]),   int'(e.rk));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation on u68; start pulses during ROUND and DONE must be ignored.
  task automatic run68(input bit dec, input bit toggle, input string tag);
    start[0] = 1'b1;
    decrypt[0] = dec;
    for (int k = 1; k <= 208; k++) begin
      tick();
      check_all(0, model(k, 68, dec), $sformatf("%s_k%0d", tag, k));
      start[0] = (k >= 100 && k <= 102) || (k == 206);
      if (toggle && k == 40) decrypt[0] = ~dec;
    end
    start[0] = 1'b0;
    decrypt[0] = 1'b0;
  endtask

  vec_t tbl [13];
  exp_t zero;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      decrypt[i] = 1'b0;
`ifdef SIMON_SEQ_ABORT_EN
      abort[i] = 1'b0;
`endif
    end
    zero = mkexp(0, 0, 0, 2'd0, 0, 0, 8'd0, 8'd0);

    tbl[0]  = '{1, 0, mkexp(1, 0, 1, 2'd0, 0, 0, 8'd0, 8'd0)};
    tbl[1]  = '{0, 0, mkexp(1, 0, 0, 2'd0, 1, 0, 8'd0, 8'd0)};
    tbl[2]  = '{0, 0, mkexp(1, 0, 0, 2'd1, 0, 0, 8'd0, 8'd0)};
    tbl[3]  = '{0, 0, mkexp(1, 0, 0, 2'd2, 0, 1, 8'd0, 8'd0)};
    tbl[4]  = '{0, 0, mkexp(1, 1, 0, 2'd0, 0, 0, 8'd0, 8'd0)};
    tbl[5]  = '{0, 0, zero};
    tbl[6]  = '{1, 1, mkexp(1, 0, 1, 2'd0, 0, 0, 8'd0, 8'd0)};
    tbl[7]  = '{1, 0, mkexp(1, 0, 0, 2'd0, 1, 0, 8'd0, 8'd0)};
    tbl[8]  = '{1, 0, mkexp(1, 0, 0, 2'd1, 0, 0, 8'd0, 8'd0)};
    tbl[9]  = '{1, 0, mkexp(1, 0, 0, 2'd2, 0, 1, 8'd0, 8'd0)};
    tbl[10] = '{1, 0, mkexp(1, 1, 0, 2'd0, 0, 0, 8'd0, 8'd0)};
    tbl[11] = '{1, 0, zero};
    tbl[12] = '{0, 0, zero};

    // Reset state on all instances.
    tick();
    tick();
    for (int i = 0; i < 3; i++) check_all(i, zero, $sformatf("reset_u%0d", i));
    reset = 1'b1;
    tick();

    // ROUNDS=1 vector table.
    for (int i = 0; i < 13; i++) begin
      start[2] = tbl[i].start;
      decrypt[2] = tbl[i].dec;
      tick();
      check_all(2, tbl[i].e, $sformatf("r1_vec%0d", i));
    end
    start[2] = 1'b0;
    decrypt[2] = 1'b0;

    // ROUNDS=68 encrypt, then decrypt with mode toggled mid-run.
    run68(1'b0, 1'b0, "enc68");
    run68(1'b1, 1'b1, "dec68");

    // ROUNDS=4 with start held high: restarts every 15 cycles.
    start[1] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      check_all(1, model(((c - 1) % 15) + 1, 4, 1'b0), $sformatf("held4_c%0d", c));
    end
    start[1] = 1'b0;
    tick();
    check_all(1, zero, "held4_release");

    // Reset asserted at round_idx=10 step 1, then a clean full run.
    start[0] = 1'b1;
    decrypt[0] = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      check_all(0, model(k, 68, 1'b0), $sformatf("prerst_k%0d", k));
      start[0] = 1'b0;
    end
    #2 reset = 1'b0;
    #1 check_all(0, zero, "rst_async");
    tick();
    check_all(0, zero, "rst_held");
    reset = 1'b1;
    tick();
    check_all(0, zero, "rst_released");
    run68(1'b0, 1'b0, "post_rst");

`ifdef SIMON_SEQ_ABORT_EN
    begin
      bit saw_done;
      // Abort at round 5 step 1.
      start[0] = 1'b1;
      for (int k = 1; k <= 18; k++) begin
        tick();
        check_all(0, model(k, 68, 1'b0), $sformatf("preabort_k%0d", k));
        start[0] = 1'b0;
      end
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      check_all(0, zero, "abort_round");
      saw_done = 1'b0;
      for (int k = 0; k < 210; k++) begin
        tick();
        if (done[0] || busy[0]) saw_done = 1'b1;
      end
      chk("abort_no_done", int'(saw_done), 0);

      // Abort while in DONE: pulse already present, then IDLE.
      start[2] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        tick();
        check_all(2, model(k, 1, 1'b0), $sformatf("abort_done_k%0d", k));
        start[2] = 1'b0;
      end
      abort[2] = 1'b1;
      tick();
      abort[2] = 1'b0;
      check_all(2, zero, "abort_done_after");

      // Start and abort together in IDLE: start wins.
      start[2] = 1'b1;
      abort[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      abort[2] = 1'b0;
      check_all(2, model(1, 1, 1'b0), "abort_start_k1");
      for (int k = 2; k <= 6; k++) begin
        tick();
        check_all(2, model(k, 1, 1'b0), $sformatf("abort_start_k%0d", k));
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
